// File: rtl/adder128_serial_io.sv
// -----------------------------------------------------------------------------
// adder128_serial_io
//
// Purpose:
//   Pin-limited wrapper around a 128-bit prefix-sum carry-lookahead adder.
//   The two 128-bit operands arrive as BEATS = 128/W narrow words over a
//   valid/ready bus. The first beat of X also carries the carry-in. The sum
//   is registered and streamed back as BEATS words. A final status word
//   follows, flagged by out_last.
//
// Parameters:
//   W          bus width in bits (8, 16, 32 or 64)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream beat valid
//   in_ready   block accepts a beat (asserted in the two load states only)
//   in_data    operand word, little-endian word order
//   in_cin     carry-in, sampled with X beat 0 only
//   out_valid  result beat valid (asserted in the unload state only)
//   out_ready  downstream accepts the beat
//   out_data   result word; the status word is {0.., ovf, cout}
//   out_last   marks the status beat
//   busy       low only when idle, waiting for X beat 0
//
// Optional feature:
//   ADDER128_OVF_EN  when defined, status bit1 reports signed overflow.
//                    When undefined, status bit1 is tied to 0.
// -----------------------------------------------------------------------------

// Kogge-Stone style parallel-prefix adder, purely combinational.
// The carry-in is folded into the bit-0 generate term. Every prefix group
// that reaches bit 0 then directly yields the carry out of its top bit.
module Prefix_Sum_CLA_128bit (
  input  logic [127:0] a,
  input  logic [127:0] b,
  input  logic         cin,
  output logic [127:0] sum,
  output logic         cout
);

  logic [127:0] p0;
  logic [127:0] g;
  logic [127:0] p;

  // Seven prefix levels with spans 1, 2, 4 .. 64. Shifting in zeros is
  // harmless: bits whose group already covers bit 0 keep their final g.
  always_comb begin
    p0 = a ^ b;
    g  = a & b;
    g[0] = (a[0] & b[0]) | (p0[0] & cin);
    p  = p0;
    for (int l = 0; l < 7; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & (p << (1 << l));
    end
    sum  = p0 ^ {g[126:0], cin};
    cout = g[127];
  end

endmodule

module adder128_serial_io #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int BEATS = 128 / W;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int IW    = $clog2(BEATS);

  localparam logic [CW-1:0] CNT_LAST_WORD = CW'(BEATS - 1);
  localparam logic [CW-1:0] CNT_STATUS    = CW'(BEATS);

  localparam logic [1:0] S_LOAD_X = 2'd0;
  localparam logic [1:0] S_LOAD_Y = 2'd1;
  localparam logic [1:0] S_CALC   = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] next_word_idx;

  logic [127:0]  x_r;
  logic [127:0]  y_r;
  logic          cin_r;
  logic [127:0]  sum_r;
  logic          cout_r;
  logic          ovf_bit;

  logic [127:0]  add_sum;
  logic          add_cout;

  logic          in_fire;
  logic          out_fire;
  logic [W-1:0]  status_word;
  logic [W-1:0]  sum_word [BEATS];

  Prefix_Sum_CLA_128bit u_adder (
    .a    (x_r),
    .b    (y_r),
    .cin  (cin_r),
    .sum  (add_sum),
    .cout (add_cout)
  );

  for (genvar k = 0; k < BEATS; k++) begin : g_sum_word
    assign sum_word[k] = sum_r[k*W +: W];
  end

`ifdef ADDER128_OVF_EN
  logic ovf_r;

  // Signed overflow: operands share a sign that the sum does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (state == S_CALC) begin
      ovf_r <= (x_r[127] == y_r[127]) & (add_sum[127] != x_r[127]);
    end
  end

  assign ovf_bit = ovf_r;
`else
  assign ovf_bit = 1'b0;
`endif

  // in_ready depends only on registered state and rst, never on in_valid.
  assign in_ready  = ((state == S_LOAD_X) || (state == S_LOAD_Y)) && !rst;
  assign out_valid = (state == S_UNLOAD);
  assign busy      = !((state == S_LOAD_X) && (cnt == '0));

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign cnt_inc       = cnt + CW'(1);
  assign next_word_idx = cnt_inc[IW-1:0];
  assign status_word   = {{(W-2){1'b0}}, ovf_bit, cout_r};

  // Main sequencer. Operands are shifted in from the top, so after BEATS
  // beats the first word sits in the lowest slice (little-endian order).
  // out_data always holds the word that is currently presented. It only
  // advances on a transfer, so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD_X;
      cnt      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      cin_r    <= 1'b0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_LOAD_X: begin
          if (in_fire) begin
            x_r <= {in_data, x_r[127:W]};
            if (cnt == '0) begin
              cin_r <= in_cin;
            end
            if (cnt == CNT_LAST_WORD) begin
              state <= S_LOAD_Y;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_LOAD_Y: begin
          if (in_fire) begin
            y_r <= {in_data, y_r[127:W]};
            if (cnt == CNT_LAST_WORD) begin
              state <= S_CALC;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_CALC: begin
          sum_r    <= add_sum;
          cout_r   <= add_cout;
          out_data <= add_sum[W-1:0];
          out_last <= 1'b0;
          state    <= S_UNLOAD;
          cnt      <= '0;
        end
        S_UNLOAD: begin
          if (out_fire) begin
            if (cnt == CNT_STATUS) begin
              state    <= S_LOAD_X;
              cnt      <= '0;
              out_data <= '0;
              out_last <= 1'b0;
            end else begin
              cnt <= cnt_inc;
              if (cnt == CNT_LAST_WORD) begin
                out_data <= status_word;
                out_last <= 1'b1;
              end else begin
                out_data <= sum_word[next_word_idx];
              end
            end
          end
        end
        default: begin
          state <= S_LOAD_X;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
